// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - elastic pipeline-stage register with optional 2-entry skid buffer
// Optional statistics counters are enabled with the PIPE_STAGE_STATS_EN macro.
module pipe_stage_buf #(
    parameter int DATA_W = 150,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              freeze,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [15:0]       flush_cnt
`endif
);

    function automatic logic [DATA_W-1:0] ctrl_mask();
        logic [DATA_W-1:0] m;
        for (int i = 0; i < DATA_W; i++) begin
            m[i] = (i < CTRL_W);
        end
        return m;
    endfunction

    localparam logic [DATA_W-1:0] CTRL_MASK = ctrl_mask();
    localparam bit                USE_SKID  = (SKID != 0);

    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic              accept;
    logic              drain;

    // The skid variant only looks at its own flop, so out_ready never reaches in_ready.
    always_comb begin
        if (USE_SKID) begin
            in_ready = rst_n & !freeze & !flush & !skid_valid_q;
        end else begin
            in_ready = rst_n & !freeze & !flush & (!main_valid_q | out_ready);
        end
    end

    assign accept    = in_valid & in_ready;
    assign drain     = main_valid_q & out_ready;
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign occupancy = 2'(main_valid_q) + 2'(skid_valid_q);

    // Any entry left empty has its control bits cleared so a bubble never enables a write.
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            main_data_d  = main_data_q & ~CTRL_MASK;
            skid_data_d  = skid_data_q & ~CTRL_MASK;
        end else if (!main_valid_q || drain) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
                skid_data_d  = skid_data_q & ~CTRL_MASK;
            end else if (accept) begin
                main_valid_d = 1'b1;
                main_data_d  = in_data;
            end else begin
                main_valid_d = 1'b0;
                main_data_d  = main_data_q & ~CTRL_MASK;
            end
        end else if (accept && USE_SKID) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (main_valid_q && !out_ready && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flush && occupancy != 2'd0 && flush_cnt_q != '1) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - directed-vector bench for pipe_stage_buf (skid and pass-through builds)
module tb_pipe_stage_buf;

    localparam int DW = 150;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          s_flush = 0, s_freeze = 0, s_in_valid = 0, s_out_ready = 0;
    logic [DW-1:0] s_in_data = '0;
    logic          s_in_ready, s_out_valid;
    logic [DW-1:0] s_out_data;
    logic [1:0]    s_occ;

    logic          n_flush = 0, n_freeze = 0, n_in_valid = 0, n_out_ready = 0;
    logic [DW-1:0] n_in_data = '0;
    logic          n_in_ready, n_out_valid;
    logic [DW-1:0] n_out_data;
    logic [1:0]    n_occ;

`ifdef PIPE_STAGE_STATS_EN
    logic [31:0] s_stall_cnt, n_stall_cnt;
    logic [15:0] s_flush_cnt, n_flush_cnt;
`endif

    pipe_stage_buf #(.DATA_W(DW), .CTRL_W(8), .SKID(1)) u_skid (
        .clk(clk), .rst_n(rst_n), .flush(s_flush), .freeze(s_freeze),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .occupancy(s_occ)
`ifdef PIPE_STAGE_STATS_EN
        , .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
`endif
    );

    pipe_stage_buf #(.DATA_W(DW), .CTRL_W(8), .SKID(0)) u_noskid (
        .clk(clk), .rst_n(rst_n), .flush(n_flush), .freeze(n_freeze),
        .in_valid(n_in_valid), .in_ready(n_in_ready), .in_data(n_in_data),
        .out_valid(n_out_valid), .out_ready(n_out_ready), .out_data(n_out_data),
        .occupancy(n_occ)
`ifdef PIPE_STAGE_STATS_EN
        , .stall_cnt(n_stall_cnt), .flush_cnt(n_flush_cnt)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [159:0] act, input logic [159:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          exp_rdy;
    int            sent, got;

    initial begin
        #2;
        chk("rst_occ", 160'(s_occ), 160'd0);
        chk("rst_valid", 160'(s_out_valid), 160'd0);
        chk("rst_data", 160'(s_out_data), 160'd0);
        chk("rst_in_ready", 160'(s_in_ready), 160'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 160'(s_in_ready), 160'd1);
        chk("post_rst_n_in_ready", 160'(n_in_ready), 160'd1);

        // Streaming with out_ready high: one beat per cycle, occupancy 1
        s_in_valid = 1; s_out_ready = 1;
        for (int i = 1; i <= 8; i++) begin
            s_in_data = DW'(i);
            #1;
            chk("t1_in_ready", 160'(s_in_ready), 160'd1);
            step();
            chk("t1_data", 160'(s_out_data), 160'(i));
            chk("t1_valid", 160'(s_out_valid), 160'd1);
            chk("t1_occ", 160'(s_occ), 160'd1);
        end
        s_in_valid = 0;
        step();
        chk("t1_empty_occ", 160'(s_occ), 160'd0);
        chk("t1_bubble_data", 160'(s_out_data), 160'd0);

        // Skid fill with downstream stalled, then drain in order
        s_out_ready = 0; s_in_valid = 1; s_in_data = DW'('h50A);
        step();
        chk("t2_occ1", 160'(s_occ), 160'd1);
        s_in_data = DW'('h60B);
        step();
        s_in_valid = 0;
        #1;
        chk("t2_occ2", 160'(s_occ), 160'd2);
        chk("t2_in_ready", 160'(s_in_ready), 160'd0);
        chk("t2_hold_a", 160'(s_out_data), 160'h50A);
        step();
        chk("t2_stable_a", 160'(s_out_data), 160'h50A);
        s_out_ready = 1;
        step();
        chk("t2_data_b", 160'(s_out_data), 160'h60B);
        chk("t2_occ_b", 160'(s_occ), 160'd1);
        step();
        chk("t2_drained_occ", 160'(s_occ), 160'd0);
        chk("t2_drained_valid", 160'(s_out_valid), 160'd0);

        // Flush with two beats held and a new beat offered
        s_out_ready = 0; s_in_valid = 1; s_in_data = DW'('h50A);
        step();
        s_in_data = DW'('h60B);
        step();
        s_flush = 1; s_in_data = DW'('h70C);
        #1;
        chk("t3_flush_in_ready", 160'(s_in_ready), 160'd0);
        step();
        s_flush = 0; s_in_valid = 0; s_out_ready = 1;
        #1;
        chk("t3_valid", 160'(s_out_valid), 160'd0);
        chk("t3_occ", 160'(s_occ), 160'd0);
        chk("t3_data_ctrl_clr", 160'(s_out_data), 160'h500);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_no_c_valid", 160'(s_out_valid), 160'd0);
            chk("t3_no_c_data", 160'(s_out_data), 160'h500);
        end

        // Freeze: held beat drains, nothing new accepted
        s_out_ready = 0; s_in_valid = 1; s_in_data = DW'('h0D);
        step();
        chk("t4_occ1", 160'(s_occ), 160'd1);
        s_freeze = 1; s_out_ready = 1; s_in_data = DW'('hEE);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4_in_ready", 160'(s_in_ready), 160'd0);
            step();
            chk("t4_occ", 160'(s_occ), 160'd0);
            chk("t4_valid", 160'(s_out_valid), 160'd0);
        end
        s_freeze = 0; s_in_valid = 0;

        // Pass-through build with out_ready toggling and continuous input
        m_valid = 0; m_data = '0; sent = 0; got = 0;
        n_in_valid = 1;
        for (int cyc = 0; cyc < 64 && got < 16; cyc++) begin
            n_out_ready = (cyc % 2 == 0);
            n_in_data = DW'(sent + 1);
            #1;
            exp_rdy = !m_valid || n_out_ready;
            chk("t5_in_ready", 160'(n_in_ready), 160'(exp_rdy));
            chk("t5_valid", 160'(n_out_valid), 160'(m_valid));
            if (m_valid && n_out_ready) begin
                chk("t5_data", 160'(n_out_data), 160'(m_data));
                got++;
            end
            if (exp_rdy) begin
                m_data = DW'(sent + 1);
                m_valid = 1;
                sent++;
            end else if (m_valid && n_out_ready) begin
                m_valid = 0;
            end
            step();
        end
        chk("t5_beats", 160'(got), 160'd16);
        n_in_valid = 0; n_out_ready = 0;

        // Asynchronous reset mid-stream
        s_out_ready = 0; s_in_valid = 1; s_in_data = DW'('h11);
        step();
        s_in_data = DW'('h22);
        step();
        s_in_valid = 0;
        chk("t6_pre_occ", 160'(s_occ), 160'd2);
        #2;
        rst_n = 0;
        #1;
        chk("t6_valid", 160'(s_out_valid), 160'd0);
        chk("t6_data", 160'(s_out_data), 160'd0);
        chk("t6_occ", 160'(s_occ), 160'd0);
        chk("t6_n_valid", 160'(n_out_valid), 160'd0);
        chk("t6_n_data", 160'(n_out_data), 160'd0);
`ifdef PIPE_STAGE_STATS_EN
        chk("t6_stall_cnt", 160'(s_stall_cnt), 160'd0);
        chk("t6_flush_cnt", 160'(s_flush_cnt), 160'd0);
`endif
        step();
        rst_n = 1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
Parametrised elastic pipeline-stage register that replaces the fixed-format inter-stage registers (ID/EX, EX/MEM, MEM/WB) with a single generic block. It carries an opaque payload with valid/ready handshakes on both sides and an optional 2-entry skid buffer that breaks the combinational ready path. It supports freeze (stall upstream) and flush (kill all in-flight beats). Control bits are cleared whenever the stage holds a bubble.

Parameters:
DATA_W, 150, payload width in bits
CTRL_W, 8, number of low payload bits treated as control (WB_EN, MEM_R_EN, ...); zeroed on bubble/flush; 1..DATA_W
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational ready pass-through

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous kill of all held beats
freeze  input  1  stop accepting input; held beats still drain
in_valid  input  1  upstream beat valid
in_ready  output  1  stage can accept a beat
in_data  input  DATA_W  upstream payload
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts the beat
out_data  output  DATA_W  output payload
occupancy  output  2  beats held, 0..(SKID+1)

Behaviour:
- Reset (rst_n=0, async): occupancy=0, out_valid=0, out_data=0, skid entry cleared. in_ready=0 while rst_n=0, and 1 from the first cycle after release when freeze=0 and flush=0.
- Transfers: input beat when in_valid&in_ready at the clock edge; output beat when out_valid&out_ready. Beats leave in strict FIFO order with no duplication and no loss, except for flushed beats.
- SKID=0:
  - in_ready = !freeze & !flush & (!out_valid | out_ready).
  - Accepted beat appears on out_data with out_valid=1 on the next cycle, so latency is 1.
- SKID=1:
  - Storage is a main entry (drives the output) plus a skid entry.
  - in_ready = !freeze & !flush & !skid_valid, where skid_valid comes from a flop only, so there is no out_ready->in_ready combinational path.
  - Accept while main is empty, or while main drains the same cycle: beat goes to main, latency 1.
  - Accept while main is held (out_ready=0): beat goes to skid; occupancy becomes 2.
  - Main drains while skid is full: skid moves to main next cycle; skid frees.
  - A simultaneous accept and drain with occupancy=1 keeps occupancy=1.
- occupancy:
  - Increments on accept-only and decrements on drain-only.
  - It is unchanged on both or neither.
  - It never exceeds SKID+1 and never underflows.
- freeze=1:
  - in_ready=0 and no input is accepted.
  - The output side keeps operating, so a held beat drains if out_ready=1.
  - out_data is stable while out_valid=1 and out_ready=0, regardless of freeze.
- flush=1 (priority over freeze and handshakes):
  - in_ready=0 in the flush cycle.
  - Next cycle: occupancy=0 and out_valid=0.
  - out_data[CTRL_W-1:0]=0; upper payload bits hold their previous value.
  - A downstream handshake in the flush cycle still counts as a completed transfer.
- Bubble rule: whenever out_valid=0, out_data[CTRL_W-1:0]=0, so a bubble never issues a write or memory enable.
- out_valid is driven from a flop only (no combinational path from in_valid).
- Reset asserted mid-stream: all beats are dropped immediately and the outputs take their reset values asynchronously.

Optional Feature:
Macro PIPE_STAGE_STATS_EN.
- Defined: adds outputs stall_cnt[31:0] and flush_cnt[15:0].
  - stall_cnt increments on each cycle with out_valid=1 and out_ready=0.
  - flush_cnt increments on each cycle with flush=1 and occupancy>0.
  - Both counters saturate at all-ones and are reset by rst_n only.
- Not defined: these ports and their logic are absent; core behaviour is identical.

Test Plan:
1. SKID=1, out_ready=1, in_valid=1 streaming 0x1..0x8 over 8 cycles -> out_data 0x1..0x8 in order, each 1 cycle later, occupancy stays 1, in_ready stays 1.
2. SKID=1, send 0xA then 0xB with out_ready=0 -> occupancy=2, in_ready=0, out_data=0xA stable. Raise out_ready -> 0xA, then 0xB next cycle, then occupancy=0.
3. occupancy=2 (0xA, 0xB), assert flush 1 cycle with in_valid=1 data 0xC -> next cycle out_valid=0, occupancy=0, out_data[CTRL_W-1:0]=0, 0xC never appears.
4. freeze=1 for 3 cycles with in_valid=1, out_ready=1, occupancy=1 -> held beat drains on the first cycle, in_ready=0 throughout, nothing accepted, occupancy=0.
5. SKID=0, out_ready toggling 1,0,1,0 with continuous in_valid -> in_ready tracks out_ready combinationally, no beat lost or duplicated over 16 beats.
6. Assert rst_n=0 mid-stream between clock edges -> out_valid, out_data and occupancy go to 0 immediately without a clock edge. With PIPE_STAGE_STATS_EN, stall_cnt and flush_cnt also read 0.
